// File: rtl/ahb_master_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_master_ctrl_pkg
//  Description : Shared AHB-Lite types (transfer kind/size/burst/protection/
//                response, slave-side bus structs), data-phase state encoding
//                and lane steering / extraction / alignment helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_master_ctrl_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } transfer_kind;

    typedef enum logic [2:0] {
        HSIZE_8  = 3'b000,
        HSIZE_16 = 3'b001,
        HSIZE_32 = 3'b010
    } transfer_size;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001
    } transfer_burst;

    typedef struct packed {
        logic cacheable;
        logic bufferable;
        logic privileged;
        logic data;
    } protection;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } transfer_resp;

    // What currently occupies the data phase
    typedef enum logic [1:0] {
        DP_EMPTY     = 2'd0,
        DP_SLAVE     = 2'd1,
        DP_DEFAULT   = 2'd2,
        DP_LOCAL_ERR = 2'd3
    } dphase_state;

    typedef struct packed {
        logic [31:0]   addr;
        logic          write;
        transfer_size  size;
        transfer_kind  trans;
        transfer_burst burst;
        protection     prot;
        logic          mastlock;
        logic [31:0]   wdata;
        logic          ready;
    } bus_slv_in;

    typedef struct packed {
        logic [31:0]  rdata;
        logic         ready;
        transfer_resp resp;
    } bus_slv_out;

    // Width of a slave index; at least one bit even for a single slave
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Replicate right-aligned write data across every lane it could land on
    function automatic logic [31:0] steer_wdata(input transfer_size size, input logic [31:0] data);
        case (size)
            HSIZE_8:  steer_wdata = {4{data[7:0]}};
            HSIZE_16: steer_wdata = {2{data[15:0]}};
            default:  steer_wdata = data;
        endcase
    endfunction

    // Pull the addressed lane(s) down to bit 0 and zero-extend; an aligned
    // half has offset[0]=0, so 8*offset selects the correct 16-bit lane
    function automatic logic [31:0] extract_rdata(input transfer_size size,
                                                  input logic [1:0]   offset,
                                                  input logic [31:0]  rdata);
        logic [31:0] shifted;
        shifted = rdata >> {offset, 3'b000};
        case (size)
            HSIZE_8:  extract_rdata = {24'h0, shifted[7:0]};
            HSIZE_16: extract_rdata = {16'h0, shifted[15:0]};
            default:  extract_rdata = rdata;
        endcase
    endfunction

    function automatic logic is_aligned(input transfer_size size, input logic [1:0] offset);
        case (size)
            HSIZE_16: is_aligned = ~offset[0];
            HSIZE_32: is_aligned = (offset == 2'b00);
            default:  is_aligned = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_master_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_master_ctrl_if
//  Description : CPU-side request/response handshake of the AHB master
//                front end. 'master' is the requester, 'slave' the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ahb_master_ctrl_if;
    import ahb_master_ctrl_pkg::*;

    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    transfer_size req_size;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface
`default_nettype wire

// File: rtl/ahb_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_addr_decoder
//  Description : Combinational address decode onto an ordered map of
//                exclusive upper bounds. Slave i owns [ADDR_MAP[i-1],
//                ADDR_MAP[i]); slave 0 starts at 0. Anything at or above the
//                last bound is reported as unmapped. ADDR_MAP[0] is the
//                least-significant element of the packed array.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_addr_decoder
    import ahb_master_ctrl_pkg::*;
#(
    parameter int unsigned                  SLAVE_COUNT = 4,
    parameter logic [SLAVE_COUNT-1:0][31:0] ADDR_MAP    = {32'h0000_4000, 32'h0000_3000,
                                                           32'h0000_2000, 32'h0000_1000}
) (
    input  logic [31:0]                         addr,
    output logic [SLAVE_COUNT-1:0]              sel,
    output logic [idx_width(SLAVE_COUNT)-1:0]   index,
    output logic                                unmapped
);

    localparam int unsigned IDX_W = idx_width(SLAVE_COUNT);

    // A non-ascending map would make regions overlap or vanish
    for (genvar g = 1; g < SLAVE_COUNT; g++) begin : g_map_check
        if (ADDR_MAP[g] <= ADDR_MAP[g-1]) begin : g_not_ascending
            $error("ahb_addr_decoder: ADDR_MAP must be strictly ascending");
        end
    end

    // Scan from the top so the lowest matching bound wins
    always_comb begin
        sel      = '0;
        index    = '0;
        unmapped = 1'b1;
        for (int i = SLAVE_COUNT - 1; i >= 0; i--) begin
            if (addr < ADDR_MAP[i]) begin
                sel      = '0;
                sel[i]   = 1'b1;
                index    = IDX_W'(i);
                unmapped = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_master_ctrl
//  Description : Single-outstanding pipelined AHB-Lite master front end with
//                lane steering, alignment checks, address decode and an
//                internal default slave for unmapped space.
//                Optional macro AHB_TIMEOUT_EN adds a wait-state watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_master_ctrl
    import ahb_master_ctrl_pkg::*;
#(
    parameter int unsigned                  SLAVE_COUNT    = 4,
    parameter logic [SLAVE_COUNT-1:0][31:0] ADDR_MAP       = {32'h0000_4000, 32'h0000_3000,
                                                              32'h0000_2000, 32'h0000_1000},
    parameter int unsigned                  TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    ahb_master_ctrl_if.slave        req_if,
    output logic                    timeout,
    output logic [SLAVE_COUNT-1:0]  sel,
    output bus_slv_in               slv_in,
    input  bus_slv_out              slv_out [SLAVE_COUNT]
);

    localparam int unsigned IDX_W = idx_width(SLAVE_COUNT);

    if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
        $error("ahb_master_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    dphase_state            r_state;
    dphase_state            w_state_next;
    logic [IDX_W-1:0]       r_index;
    logic                   r_write;
    transfer_size           r_size;
    logic [1:0]             r_off;
    logic [31:0]            r_wdata;
    logic                   r_err_cancel;

    logic [SLAVE_COUNT-1:0] w_dec_sel;
    logic [IDX_W-1:0]       w_dec_index;
    logic                   w_dec_unmapped;
    logic                   w_aligned;
    logic                   w_issue;
    logic                   w_accept;
    logic                   w_done;
    logic                   w_timeout_hit;
    logic                   w_tgt_ready;
    transfer_resp           w_tgt_resp;
    logic [31:0]            w_tgt_rdata;

    ahb_addr_decoder #(
        .SLAVE_COUNT (SLAVE_COUNT),
        .ADDR_MAP    (ADDR_MAP)
    ) u_decoder (
        .addr     (req_if.req_addr),
        .sel      (w_dec_sel),
        .index    (w_dec_index),
        .unmapped (w_dec_unmapped)
    );

    assign w_aligned = is_aligned(req_if.req_size, req_if.req_addr[1:0]);

    // Response of whatever owns the data phase; the default slave answers
    // ERROR with ready low first, then ready high once err_cancel is set
    always_comb begin
        w_tgt_ready = 1'b1;
        w_tgt_resp  = RESP_OKAY;
        w_tgt_rdata = '0;
        case (r_state)
            DP_SLAVE: begin
                for (int i = 0; i < SLAVE_COUNT; i++) begin
                    if (r_index == IDX_W'(i)) begin
                        w_tgt_ready = slv_out[i].ready;
                        w_tgt_resp  = slv_out[i].resp;
                        w_tgt_rdata = slv_out[i].rdata;
                    end
                end
            end
            DP_DEFAULT: begin
                w_tgt_ready = r_err_cancel;
                w_tgt_resp  = RESP_ERROR;
            end
            DP_LOCAL_ERR: begin
                w_tgt_resp  = RESP_ERROR;
            end
            default: begin
                w_tgt_ready = 1'b1;
            end
        endcase
    end

`ifdef AHB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout;

    assign w_timeout_hit = (r_state != DP_EMPTY) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign timeout       = r_timeout;

    // Count wait states of the pending data phase; restart on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_done) begin
            r_wait_cnt <= '0;
        end else if ((r_state != DP_EMPTY) && !w_tgt_ready) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // Sticky record that a transfer was abandoned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign timeout       = 1'b0;
`endif

    assign w_done            = (r_state != DP_EMPTY) && (w_tgt_ready || w_timeout_hit);
    assign req_if.req_ready  = w_tgt_ready && !r_err_cancel && !w_timeout_hit;
    assign w_accept          = req_if.req_valid && req_if.req_ready;
    assign w_issue           = req_if.req_valid && w_aligned && !w_dec_unmapped &&
                               !r_err_cancel && !w_timeout_hit;

    assign req_if.rsp_valid  = w_done;
    assign req_if.rsp_error  = w_done && ((w_tgt_resp == RESP_ERROR) || w_timeout_hit);
    assign req_if.rsp_rdata  = (w_done && !r_write) ? extract_rdata(r_size, r_off, w_tgt_rdata) : '0;

    assign sel = w_issue ? w_dec_sel : '0;

    // Address phase follows the live request; write data comes from the
    // data-phase register so it lines up with the previous address
    always_comb begin
        slv_in          = '0;
        slv_in.addr     = req_if.req_valid ? req_if.req_addr  : '0;
        slv_in.write    = req_if.req_valid && req_if.req_write;
        slv_in.size     = req_if.req_valid ? req_if.req_size  : HSIZE_8;
        slv_in.trans    = w_issue ? TRANS_NONSEQ : TRANS_IDLE;
        slv_in.burst    = BURST_SINGLE;
        slv_in.prot     = '{cacheable: 1'b0, bufferable: 1'b0, privileged: 1'b1, data: 1'b1};
        slv_in.mastlock = 1'b0;
        slv_in.wdata    = r_wdata;
        slv_in.ready    = w_tgt_ready;
    end

    // Data-phase state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DP_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next data-phase owner: a new accept replaces the completing transfer
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            if (!w_aligned) begin
                w_state_next = DP_LOCAL_ERR;
            end else if (w_dec_unmapped) begin
                w_state_next = DP_DEFAULT;
            end else begin
                w_state_next = DP_SLAVE;
            end
        end else if (w_done) begin
            w_state_next = DP_EMPTY;
        end
    end

    // Capture request attributes needed during the data phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index <= '0;
            r_write <= 1'b0;
            r_size  <= HSIZE_8;
            r_off   <= 2'b00;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_index <= w_dec_index;
            r_write <= req_if.req_write;
            r_size  <= req_if.req_size;
            r_off   <= req_if.req_addr[1:0];
            r_wdata <= steer_wdata(req_if.req_size, req_if.req_wdata);
        end
    end

    // First cycle of a two-cycle ERROR blocks the next address phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cancel <= 1'b0;
        end else if (w_done) begin
            r_err_cancel <= 1'b0;
        end else if ((r_state != DP_EMPTY) && !w_tgt_ready && (w_tgt_resp == RESP_ERROR)) begin
            r_err_cancel <= 1'b1;
        end
    end

endmodule
`default_nettype wire
